// File: rtl/vga_pkg.sv
// Shared definitions for the VGA pipeline: active window, colours and the sprite mode type.
package vga_pkg;

  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned H_OFFSET = 48;
  localparam int unsigned V_OFFSET = 33;

  typedef logic [11:0] rgb12_t;

  localparam rgb12_t SPR_COLOR   = 12'hF80;
  localparam rgb12_t BG_COLOR    = 12'h00F;
  localparam rgb12_t EDGE_COLOR  = 12'hFFF;
  localparam rgb12_t BLANK_COLOR = 12'h000;

  typedef enum logic {ModeManual, ModeAuto} mode_e;

  // Compare before add/subtract so the result saturates at the limit and never wraps.
  function automatic logic [9:0] step_inc(input logic [9:0] pos, input logic [9:0] step,
                                          input logic [9:0] lim);
    return (pos >= lim - step) ? lim : pos + step;
  endfunction

  function automatic logic [9:0] step_dec(input logic [9:0] pos, input logic [9:0] step);
    return (pos <= step) ? '0 : pos - step;
  endfunction

endpackage

// File: rtl/btn_sync.sv
// Two-flop synchroniser for a bundle of asynchronous level inputs.
module btn_sync #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q, sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/vga_sprite_engine.sv
// Pixel source: background, 1-pixel screen frame and one movable sprite, updated once per
// frame in vertical blanking from buttons (manual) or by bouncing off the edges (auto).
module vga_sprite_engine
  import vga_pkg::*;
#(
  parameter int unsigned SPR_W = 32,
  parameter int unsigned SPR_H = 32,
  parameter int unsigned STEP  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [10:0] h_cnt,
  input  logic [10:0] v_cnt,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        auto_en,
  output logic [3:0]  pix_r,
  output logic [3:0]  pix_g,
  output logic [3:0]  pix_b,
  output logic [9:0]  spr_x,
  output logic [9:0]  spr_y,
  output logic        frame_tick
);

  localparam logic [9:0]  X_MAX   = 10'(H_ACTIVE - SPR_W);
  localparam logic [9:0]  Y_MAX   = 10'(V_ACTIVE - SPR_H);
  localparam logic [9:0]  X_INIT  = 10'((H_ACTIVE - SPR_W) / 2);
  localparam logic [9:0]  Y_INIT  = 10'((V_ACTIVE - SPR_H) / 2);
  localparam logic [9:0]  STP     = 10'(STEP);
  localparam logic [10:0] H_START = 11'(H_OFFSET);
  localparam logic [10:0] H_END   = 11'(H_OFFSET + H_ACTIVE);
  localparam logic [10:0] V_START = 11'(V_OFFSET);
  localparam logic [10:0] V_END   = 11'(V_OFFSET + V_ACTIVE);
  localparam logic [10:0] X_LAST  = 11'(H_ACTIVE - 1);
  localparam logic [10:0] Y_LAST  = 11'(V_ACTIVE - 1);
  localparam logic [10:0] SW_M1   = 11'(SPR_W - 1);
  localparam logic [10:0] SH_M1   = 11'(SPR_H - 1);
  localparam logic [10:0] TICK_V  = 11'(V_OFFSET + V_ACTIVE);

  logic [4:0] sync;
  logic       up_s, down_s, left_s, right_s, auto_s;

  btn_sync #(.WIDTH(5)) u_btn_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     ({auto_en, btn_right, btn_left, btn_down, btn_up}),
    .q     (sync)
  );

  assign {auto_s, right_s, left_s, down_s, up_s} = sync;

  // Rising edge of the first blanking line start, so stuck counters give a single tick.
  logic match, match_q, tick, frame_tick_q;
  assign match = (h_cnt == '0) && (v_cnt == TICK_V);
  assign tick  = match && !match_q;

  mode_e      mode_q, mode_d;
  logic [9:0] spr_x_q, spr_y_q, x_d, y_d;
  logic       dx_q, dy_q, dx_d, dy_d;

  always_comb begin
    mode_d = mode_q;
    unique case (mode_q)
      ModeManual: if (auto_s)  mode_d = ModeAuto;
      ModeAuto:   if (!auto_s) mode_d = ModeManual;
    endcase
  end

  // Movement uses the mode being entered on this tick, so auto_en acts from the next tick.
  always_comb begin
    x_d  = spr_x_q;
    y_d  = spr_y_q;
    dx_d = dx_q;
    dy_d = dy_q;
    if (mode_d == ModeAuto) begin
      if (dx_q) begin
        x_d  = step_inc(spr_x_q, STP, X_MAX);
        dx_d = !(spr_x_q >= X_MAX - STP);
      end else begin
        x_d  = step_dec(spr_x_q, STP);
        dx_d = (spr_x_q <= STP);
      end
      if (dy_q) begin
        y_d  = step_inc(spr_y_q, STP, Y_MAX);
        dy_d = !(spr_y_q >= Y_MAX - STP);
      end else begin
        y_d  = step_dec(spr_y_q, STP);
        dy_d = (spr_y_q <= STP);
      end
    end else begin
      if (right_s && !left_s)      x_d = step_inc(spr_x_q, STP, X_MAX);
      else if (left_s && !right_s) x_d = step_dec(spr_x_q, STP);
      if (down_s && !up_s)         y_d = step_inc(spr_y_q, STP, Y_MAX);
      else if (up_s && !down_s)    y_d = step_dec(spr_y_q, STP);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      match_q      <= 1'b0;
      frame_tick_q <= 1'b0;
      mode_q       <= ModeManual;
      spr_x_q      <= X_INIT;
      spr_y_q      <= Y_INIT;
      dx_q         <= 1'b1;
      dy_q         <= 1'b1;
    end else begin
      match_q      <= match;
      frame_tick_q <= tick;
      if (tick) begin
        mode_q  <= mode_d;
        spr_x_q <= x_d;
        spr_y_q <= y_d;
        dx_q    <= dx_d;
        dy_q    <= dy_d;
      end
    end
  end

  // x/y may underflow outside the active window; only used when active.
  logic [10:0] x, y, sx, sy;
  logic        active, in_x, in_y, on_edge;
  rgb12_t      colour_d, pix_q;

  always_comb begin
    x        = h_cnt - H_START;
    y        = v_cnt - V_START;
    sx       = {1'b0, spr_x_q};
    sy       = {1'b0, spr_y_q};
    active   = (h_cnt >= H_START) && (h_cnt < H_END) && (v_cnt >= V_START) && (v_cnt < V_END);
    in_x     = (x >= sx) && (x <= sx + SW_M1);
    in_y     = (y >= sy) && (y <= sy + SH_M1);
    on_edge  = (((x == sx) || (x == sx + SW_M1)) && in_y) ||
               (((y == sy) || (y == sy + SH_M1)) && in_x);
    colour_d = BG_COLOR;
    if (!active)                                                 colour_d = BLANK_COLOR;
    else if (on_edge)                                            colour_d = EDGE_COLOR;
    else if (in_x && in_y)                                       colour_d = SPR_COLOR;
    else if (x == '0 || x == X_LAST || y == '0 || y == Y_LAST)   colour_d = EDGE_COLOR;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pix_q <= BLANK_COLOR;
    else        pix_q <= colour_d;
  end

  assign {pix_r, pix_g, pix_b} = pix_q;
  assign spr_x      = spr_x_q;
  assign spr_y      = spr_y_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_vga_sprite_engine.sv
// Self-checking bench: behavioural screen/sprite model compared every cycle, plus pinned values.
module tb_vga_sprite_engine;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [10:0] h_cnt, v_cnt;
  logic        btn_up, btn_down, btn_left, btn_right, auto_en;
  logic [3:0]  pix_r, pix_g, pix_b;
  logic [9:0]  spr_x, spr_y;
  logic        frame_tick;

  vga_sprite_engine dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .h_cnt      (h_cnt),
    .v_cnt      (v_cnt),
    .btn_up     (btn_up),
    .btn_down   (btn_down),
    .btn_left   (btn_left),
    .btn_right  (btn_right),
    .auto_en    (auto_en),
    .pix_r      (pix_r),
    .pix_g      (pix_g),
    .pix_b      (pix_b),
    .spr_x      (spr_x),
    .spr_y      (spr_y),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  int unsigned n_chk = 0, n_pass = 0;
  bit          armed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  // Reference model state
  int         mx, my;
  bit         dx, dy, pm, e_tick;
  logic [4:0] s1, s2;
  logic [11:0] e_pix;

  function automatic logic [11:0] colour(input int x, input int y, input int sx, input int sy);
    bit ix, iy;
    if (x < 0 || x >= 640 || y < 0 || y >= 480) return 12'h000;
    ix = (x >= sx) && (x <= sx + 31);
    iy = (y >= sy) && (y <= sy + 31);
    if (((x == sx || x == sx + 31) && iy) || ((y == sy || y == sy + 31) && ix)) return 12'hFFF;
    if (ix && iy) return 12'hF80;
    if (x == 0 || x == 639 || y == 0 || y == 479) return 12'hFFF;
    return 12'h00F;
  endfunction

  task automatic model_step();
    logic [4:0] b;
    bit m;
    if (rst_n !== 1'b1) begin
      mx = 304; my = 224; dx = 1; dy = 1; pm = 0; e_tick = 0; e_pix = 0; s1 = 0; s2 = 0;
      return;
    end
    b  = s2;
    s2 = s1;
    s1 = {auto_en, btn_right, btn_left, btn_down, btn_up};
    e_pix  = colour(int'(h_cnt) - 48, int'(v_cnt) - 33, mx, my);
    m      = (h_cnt == 0) && (v_cnt == 513);
    e_tick = m && !pm;
    pm     = m;
    if (e_tick) begin
      if (b[4]) begin
        if (dx) begin if (mx + 2 >= 608) begin mx = 608; dx = 0; end else mx += 2; end
        else    begin if (mx - 2 <= 0)   begin mx = 0;   dx = 1; end else mx -= 2; end
        if (dy) begin if (my + 2 >= 448) begin my = 448; dy = 0; end else my += 2; end
        else    begin if (my - 2 <= 0)   begin my = 0;   dy = 1; end else my -= 2; end
      end else begin
        if (b[3] && !b[2]) mx = (mx + 2 > 608) ? 608 : mx + 2;
        if (b[2] && !b[3]) mx = (mx - 2 < 0) ? 0 : mx - 2;
        if (b[1] && !b[0]) my = (my + 2 > 448) ? 448 : my + 2;
        if (b[0] && !b[1]) my = (my - 2 < 0) ? 0 : my - 2;
      end
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    model_step();
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (armed && rst_n === 1'b1) begin
      chk("pix", {20'd0, pix_r, pix_g, pix_b}, {20'd0, e_pix});
      chk("frame_tick", {31'd0, frame_tick}, {31'd0, e_tick});
      chk("spr_x", {22'd0, spr_x}, mx);
      chk("spr_y", {22'd0, spr_y}, my);
    end
  end

  task automatic drive(input int h, input int v);
    @(negedge clk);
    h_cnt = 11'(h);
    v_cnt = 11'(v);
  endtask

  // Compressed frame: a few pixels around the sprite and anywhere, then the tick position.
  task automatic run_frame();
    for (int i = 0; i < 6; i++)
      drive(48 + mx + $urandom_range(0, 37) - 3, 33 + my + $urandom_range(0, 37) - 3);
    for (int i = 0; i < 2; i++) drive($urandom_range(0, 799), $urandom_range(0, 524));
    drive(0, 513);
    drive(1, 513);
  endtask

  task automatic run_frames(input int n);
    for (int i = 0; i < n; i++) run_frame();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  int ticks;

  initial begin
    rst_n = 1'b0;
    h_cnt = 0; v_cnt = 0;
    {btn_up, btn_down, btn_left, btn_right, auto_en} = '0;
    repeat (3) @(negedge clk);
    chk("reset_pix", {pix_r, pix_g, pix_b}, 12'h000);
    chk("reset_tick", frame_tick, 1'b0);
    rst_n = 1'b1;
    armed = 1;
    chk("reset_x", spr_x, 10'd304);
    chk("reset_y", spr_y, 10'd224);

    // Pinned render values, one clock of latency
    drive(48 + 304, 33 + 224); @(negedge clk);
    chk("pix_outline", {pix_r, pix_g, pix_b}, 12'hFFF);
    drive(48 + 320, 33 + 240); @(negedge clk);
    chk("pix_interior", {pix_r, pix_g, pix_b}, 12'hF80);
    drive(48 + 100, 33 + 100); @(negedge clk);
    chk("pix_bg", {pix_r, pix_g, pix_b}, 12'h00F);
    drive(10, 33 + 100); @(negedge clk);
    chk("pix_blank", {pix_r, pix_g, pix_b}, 12'h000);
    drive(48 + 639, 33 + 50); @(negedge clk);
    chk("pix_frame", {pix_r, pix_g, pix_b}, 12'hFFF);

    // Real counting across the tick position, then counters stuck on it
    ticks = 0;
    for (int h = 795; h < 800; h++) drive(h, 512);
    for (int h = 0; h < 4; h++) begin drive(h, 513); #1 ticks += int'(frame_tick); end
    for (int i = 0; i < 6; i++) begin drive(0, 513); #1 ticks += int'(frame_tick); end
    drive(5, 513); #1 ticks += int'(frame_tick);
    chk("stuck_one_tick", ticks, 2);

    // Manual right: saturates at 608 on frame 152
    btn_right = 1;
    run_frames(151);
    chk("right_151", spr_x, 10'd606);
    run_frame();
    chk("right_152", spr_x, 10'd608);
    run_frames(248);
    chk("right_400", spr_x, 10'd608);
    btn_left = 1;
    run_frames(10);
    chk("both_lr", spr_x, 10'd608);
    {btn_left, btn_right} = '0;

    // Manual up: reaches 0 on frame 112 and stays
    btn_up = 1;
    run_frames(112);
    chk("up_112", spr_y, 10'd0);
    run_frames(8);
    chk("up_120", spr_y, 10'd0);
    btn_up = 0;

    // Auto bounce from the reset position
    do_reset();
    auto_en = 1;
    run_frames(112);
    chk("auto_y_112", spr_y, 10'd448);
    run_frame();
    chk("auto_y_113", spr_y, 10'd446);
    run_frames(39);
    chk("auto_x_152", spr_x, 10'd608);
    run_frame();
    chk("auto_x_153", spr_x, 10'd606);

    // Reset mid-line in auto mode
    drive(200, 100);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_pix", {pix_r, pix_g, pix_b}, 12'h000);
    chk("midrst_tick", frame_tick, 1'b0);
    chk("midrst_x", spr_x, 10'd304);
    chk("midrst_y", spr_y, 10'd224);
    auto_en = 0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // auto_en raised mid-frame acts only at the next tick
    run_frame();
    chk("manual_idle_x", spr_x, 10'd304);
    drive(300, 200); drive(301, 200);
    auto_en = 1;
    for (int i = 0; i < 5; i++) drive(302 + i, 200);
    chk("midframe_x", spr_x, 10'd304);
    chk("midframe_y", spr_y, 10'd224);
    run_frame();
    chk("toggle_x", spr_x, 10'd306);
    chk("toggle_y", spr_y, 10'd226);

    // Randomised frames with random buttons and mode, changes landing anywhere in the frame
    for (int f = 0; f < 300; f++) begin
      {btn_up, btn_down, btn_left, btn_right} = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) auto_en = ~auto_en;
      run_frame();
      if ($urandom_range(0, 3) == 0) begin
        drive($urandom_range(0, 799), $urandom_range(0, 524));
        btn_left = ~btn_left;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
